// File: rtl/regfile_wb_pkg.sv
// Shared widths, buffer entry type and register-decode helper for the
// register-file write-back block.
package regfile_wb_pkg;

    localparam int REG_AW         = 5;
    localparam int DATA_W         = 32;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int NUM_REGS       = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // One-hot register select; r0 is hard-wired, so it never decodes.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] a);
        logic [NUM_REGS-1:0] oh;
        if (a == {REG_AW{1'b0}}) begin
            oh = {NUM_REGS{1'b0}};
        end else begin
            oh = {{(NUM_REGS-1){1'b0}}, 1'b1} << a;
        end
        return oh;
    endfunction

endpackage

// File: rtl/regfile_wb_fifo.sv
// wb_fifo: synchronous buffer for long-latency write-back results with a
// registered occupancy count. Push when full and pop when empty are ignored.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               push_s;
    logic               pop_s;

    assign full   = (count_r == CNT_W'(DEPTH));
    assign empty  = (count_r == {CNT_W{1'b0}});
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    assign head   = mem_r[rd_ptr_r];

    // Entry storage; data only, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// regfile_wb: arbitrates single-cycle ALU results against buffered
// long-latency results onto one registered regfile write port.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                a_valid,
    input  logic [REG_AW-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                b_valid,
    input  logic [REG_AW-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_data,
    output logic                b_ready,
    input  logic                issue_valid,
    input  logic [REG_AW-1:0]   issue_addr,
    output logic                we,
    output logic [REG_AW-1:0]   waddr,
    output logic [DATA_W-1:0]   wdata,
    output logic [NUM_REGS-1:0] pending
);

    logic                a_elig_s;
    logic                push_s;
    logic                pop_s;
    logic                full_s;
    logic                empty_s;
    wb_entry_t           head_s;
    wb_entry_t           push_entry_s;
    logic [NUM_REGS-1:0] set_mask_s;
    logic [NUM_REGS-1:0] clr_mask_s;
    logic [NUM_REGS-1:0] pending_nxt_s;
    logic [NUM_REGS-1:0] pending_r;

    // b_ready comes from the registered count, so a same-cycle pop never raises it.
    assign b_ready      = !rst && !full_s;
    assign push_s       = b_valid && b_ready && (b_addr != {REG_AW{1'b0}});
    assign a_elig_s     = a_valid && !flush && (a_addr != {REG_AW{1'b0}});
    assign pop_s        = !stall && !a_elig_s && !empty_s;
    assign push_entry_s = '{addr: b_addr, data: b_data};
    assign pending      = pending_r;

    wb_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head       (head_s),
        .full       (full_s),
        .empty      (empty_s)
    );

    // Write port: ALU result first, then buffer head; held across stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we    <= 1'b0;
            waddr <= {REG_AW{1'b0}};
            wdata <= {DATA_W{1'b0}};
        end else if (!stall) begin
            if (a_elig_s) begin
                we    <= 1'b1;
                waddr <= a_addr;
                wdata <= a_data;
            end else if (!empty_s) begin
                we    <= 1'b1;
                waddr <= head_s.addr;
                wdata <= head_s.data;
            end else begin
                we    <= 1'b0;
            end
        end
    end

    // Scoreboard next state: a new issue wins over a retiring write to the same register.
    always_comb begin
        set_mask_s    = {NUM_REGS{1'b0}};
        clr_mask_s    = {NUM_REGS{1'b0}};
        pending_nxt_s = pending_r;
        if (issue_valid) begin
            set_mask_s = reg_onehot(issue_addr);
        end else begin
            set_mask_s = {NUM_REGS{1'b0}};
        end
        if (pop_s) begin
            clr_mask_s = reg_onehot(head_s.addr);
        end else begin
            clr_mask_s = {NUM_REGS{1'b0}};
        end
        pending_nxt_s = ((pending_r & ~clr_mask_s) | set_mask_s) & ~{{(NUM_REGS-1){1'b0}}, 1'b1};
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= {NUM_REGS{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: a queue-based reference of the buffer
// and scoreboard predicts each write, which is queued and popped on output.
module tb_regfile_wb;
    import regfile_wb_pkg::*;

    localparam int DEPTH = 4;

    logic                clk;
    logic                rst;
    logic                stall;
    logic                flush;
    logic                a_valid;
    logic [REG_AW-1:0]   a_addr;
    logic [DATA_W-1:0]   a_data;
    logic                b_valid;
    logic [REG_AW-1:0]   b_addr;
    logic [DATA_W-1:0]   b_data;
    logic                b_ready;
    logic                issue_valid;
    logic [REG_AW-1:0]   issue_addr;
    logic                we;
    logic [REG_AW-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic [NUM_REGS-1:0] pending;

    int checks = 0;
    int errors = 0;

    // Reference state
    wb_entry_t           mq[$];
    wb_entry_t           exp_q[$];
    logic                m_we;
    logic [REG_AW-1:0]   m_waddr;
    logic [DATA_W-1:0]   m_wdata;
    logic [NUM_REGS-1:0] m_pend;
    logic                b_acc_last;

    regfile_wb #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .a_valid     (a_valid),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 1'b0; flush = 1'b0;
        a_valid = 1'b0; a_addr = 5'd0; a_data = 32'd0;
        b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
        issue_valid = 1'b0; issue_addr = 5'd0;
    endtask

    // One clock: predict from the driven inputs, advance, then compare.
    task automatic step();
        logic      a_ok;
        logic      do_pop;
        wb_entry_t hd;
        wb_entry_t e;
        wb_entry_t got;
        a_ok   = a_valid && !flush && (a_addr != 5'd0);
        do_pop = !stall && !a_ok && (mq.size() > 0);
        b_acc_last = b_valid && (mq.size() < DEPTH);
        if (!stall) begin
            if (a_ok) begin
                m_we = 1'b1; m_waddr = a_addr; m_wdata = a_data;
            end else if (do_pop) begin
                hd = mq[0];
                m_we = 1'b1; m_waddr = hd.addr; m_wdata = hd.data;
            end else begin
                m_we = 1'b0;
            end
            if (m_we) begin
                e.addr = m_waddr; e.data = m_wdata;
                exp_q.push_back(e);
            end
        end
        if (do_pop) begin
            hd = mq.pop_front();
            m_pend[hd.addr] = 1'b0;
        end
        if (issue_valid) m_pend[issue_addr] = 1'b1;
        m_pend[0] = 1'b0;
        if (b_acc_last && (b_addr != 5'd0)) begin
            e.addr = b_addr; e.data = b_data;
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
        check_eq("we", {31'd0, we}, {31'd0, m_we});
        if (!stall && m_we) begin
            if (exp_q.size() == 0) begin
                check_eq("write_expected", 32'd0, 32'd1);
            end else begin
                got = exp_q.pop_front();
                check_eq("waddr", {27'd0, waddr}, {27'd0, got.addr});
                check_eq("wdata", wdata, got.data);
            end
        end else begin
            check_eq("waddr_hold", {27'd0, waddr}, {27'd0, m_waddr});
            check_eq("wdata_hold", wdata, m_wdata);
        end
        check_eq("pending", pending, m_pend);
        check_eq("b_ready", {31'd0, b_ready}, {31'd0, (mq.size() < DEPTH) ? 1'b1 : 1'b0});
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
    task automatic mid_reset();
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_we", {31'd0, we}, 32'd0);
        check_eq("rst_waddr", {27'd0, waddr}, 32'd0);
        check_eq("rst_wdata", wdata, 32'd0);
        check_eq("rst_pending", pending, 32'd0);
        check_eq("rst_b_ready", {31'd0, b_ready}, 32'd0);
        mq.delete(); exp_q.delete();
        m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0; m_pend = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_b_ready", {31'd0, b_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        idle_inputs();
        rst = 1'b1;
        m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0; m_pend = 32'd0;
        @(posedge clk);
        #1;
        check_eq("reset_we", {31'd0, we}, 32'd0);
        check_eq("reset_pending", pending, 32'd0);
        check_eq("reset_b_ready", {31'd0, b_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("first_b_ready", {31'd0, b_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single ALU write, then idle
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234;
        step();
        idle_inputs();
        step();

        // A keeps priority while two B results queue up behind it
        issue_valid = 1'b1; issue_addr = 5'd3; step();
        issue_addr = 5'd4; step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h70 + i;
            b_valid = (i < 2); b_addr = (i == 0) ? 5'd3 : 5'd4; b_data = (i == 0) ? 32'hA : 32'hB;
            step();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) step();

        // Fill the buffer while A blocks draining
        n = 0;
        a_valid = 1'b1; a_addr = 5'd1;
        for (int i = 0; i < 12 && n < 4; i++) begin
            a_data = 32'h100 + i;
            b_valid = 1'b1; b_addr = 5'd10 + 5'(n); b_data = 32'h200 + n;
            step();
            if (b_acc_last) n++;
        end
        check_eq("b_ready_full", {31'd0, b_ready}, 32'd0);
        b_addr = 5'd14; b_data = 32'h204;
        step();
        check_eq("fifth_held", {31'd0, b_acc_last}, 32'd0);
        a_valid = 1'b0;
        for (int i = 0; i < 10 && n < 5; i++) begin
            step();
            if (b_acc_last) n++;
        end
        check_eq("fifth_accepted", n, 5);
        idle_inputs();
        for (int i = 0; i < 6; i++) step();

        // Stall freezes write port and drain
        a_valid = 1'b1; a_addr = 5'd8; a_data = 32'h88;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h55;
        step();
        idle_inputs();
        stall = 1'b1;
        step(); step();
        stall = 1'b0;
        step(); step();

        // Flushed A and B push to r0 produce nothing
        a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h66; flush = 1'b1;
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h99;
        step();
        idle_inputs();
        step(); step();

        // Issue wins over retiring write to the same register
        issue_valid = 1'b1; issue_addr = 5'd2; step();
        idle_inputs();
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22; step();
        idle_inputs();
        issue_valid = 1'b1; issue_addr = 5'd2; step();
        idle_inputs();
        step();
        check_eq("pending2_kept", {31'd0, pending[2]}, 32'd1);

        // Reset in the middle of a drain
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
        for (int i = 0; i < 3; i++) begin
            b_valid = 1'b1; b_addr = 5'd20 + 5'(i); b_data = 32'h300 + i;
            issue_valid = 1'b1; issue_addr = 5'd20 + 5'(i);
            step();
        end
        idle_inputs();
        step();
        mid_reset();
        for (int i = 0; i < 4; i++) step();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            stall       = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 4) == 0);
            a_valid     = ($urandom_range(0, 2) == 0);
            a_addr      = 5'($urandom_range(0, 31));
            a_data      = $urandom;
            b_valid     = ($urandom_range(0, 1) == 0);
            b_addr      = 5'($urandom_range(0, 31));
            b_data      = $urandom;
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_addr  = 5'($urandom_range(0, 31));
            step();
        end
        idle_inputs();
        for (int i = 0; i < 8; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
